// File: rtl/pll_tick_gen.sv
`default_nettype none
// ============================================================================
// Module      : pll_tick_gen
// Description : Multi-channel clock-enable generator on the PLL output clock.
//               Qualifies the raw PLL lock flag over LOCK_CYCLES consecutive
//               locked samples, then emits per-channel divided tick pulses and
//               square-wave enables with glitch-free run-time ratio changes.
//               Lock loss in RUN is recorded in a sticky flag.
// Revision    : 1.0 - initial release
// ============================================================================
module pll_tick_gen #(
    parameter int NCH         = 4,
    parameter int CNT_W       = 16,
    parameter int LOCK_CYCLES = 256
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 pll_locked,
    input  logic [NCH-1:0]       ch_en,
    input  logic [NCH*CNT_W-1:0] div,
    output logic [NCH-1:0]       tick,
    output logic [NCH-1:0]       sq,
    output logic                 ready,
    output logic                 lock_lost
);

    localparam int LOCK_W = $clog2(LOCK_CYCLES + 1);
    localparam logic [LOCK_W-1:0] C_LOCK_LAST = LOCK_W'(LOCK_CYCLES - 1);

    typedef enum logic [0:0] {
        ST_LOCK_WAIT = 1'b0,
        ST_RUN       = 1'b1
    } state_t;

    state_t            r_state;
    logic [LOCK_W-1:0] r_lock_cnt;
    logic              r_ready;
    logic              r_lock_lost;

    // Channels may only count while in RUN and the lock is still present at
    // this edge; a lock drop clears every channel on the same edge.
    logic w_run_ok;
    assign w_run_ok = (r_state == ST_RUN) && pll_locked;

    // Lock qualification FSM with registered ready and sticky lock-loss flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_LOCK_WAIT;
            r_lock_cnt  <= '0;
            r_ready     <= 1'b0;
            r_lock_lost <= 1'b0;
        end else begin
            case (r_state)
                ST_LOCK_WAIT: begin
                    if (!pll_locked) begin
                        r_lock_cnt <= '0;
                    end else begin
                        r_lock_cnt <= r_lock_cnt + 1'b1;
                        if (r_lock_cnt == C_LOCK_LAST) begin
                            r_state <= ST_RUN;
                            r_ready <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (!pll_locked) begin
                        r_state     <= ST_LOCK_WAIT;
                        r_lock_cnt  <= '0;
                        r_ready     <= 1'b0;
                        r_lock_lost <= 1'b1;
                    end
                end
                default: begin
                    r_state    <= ST_LOCK_WAIT;
                    r_lock_cnt <= '0;
                    r_ready    <= 1'b0;
                end
            endcase
        end
    end

    assign ready     = r_ready;
    assign lock_lost = r_lock_lost;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic [CNT_W-1:0] w_div;
        logic [CNT_W-1:0] w_ratio;
        logic             w_last;
        logic [CNT_W-1:0] r_cnt;
        logic [CNT_W-1:0] r_n_act;
        logic             r_tick;
        logic             r_sq;

        // A ratio of zero behaves as one (tick every cycle).
        assign w_div   = div[i*CNT_W +: CNT_W];
        assign w_ratio = (w_div == '0) ? CNT_W'(1) : w_div;
        // n_act is never zero once loaded, so n_act-1 cannot underflow.
        assign w_last  = (r_cnt == (r_n_act - CNT_W'(1)));

        // Divider: the shadow ratio n_act is only reloaded while idle or at
        // terminal count, so a ratio change never truncates a period.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_cnt   <= '0;
                r_n_act <= CNT_W'(1);
                r_tick  <= 1'b0;
                r_sq    <= 1'b0;
            end else if (!(w_run_ok && ch_en[i])) begin
                r_cnt   <= '0;
                r_n_act <= w_ratio;
                r_tick  <= 1'b0;
                r_sq    <= 1'b0;
            end else if (w_last) begin
                r_cnt   <= '0;
                r_n_act <= w_ratio;
                r_tick  <= 1'b1;
                r_sq    <= ~r_sq;
            end else begin
                r_cnt   <= r_cnt + CNT_W'(1);
                r_tick  <= 1'b0;
            end
        end

        assign tick[i] = r_tick;
        assign sq[i]   = r_sq;
    end

endmodule
`default_nettype wire

// File: tb/tb_pll_tick_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_pll_tick_gen
// Description : Self-checking bench for pll_tick_gen (NCH=4, CNT_W=16,
//               LOCK_CYCLES=8). Table-driven lock-up and divider vectors,
//               followed by directed multi-cycle corner-case sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pll_tick_gen;

    localparam int NCH         = 4;
    localparam int CNT_W       = 16;
    localparam int LOCK_CYCLES = 8;

    logic                 clk;
    logic                 rst;
    logic                 pll_locked;
    logic [NCH-1:0]       ch_en;
    logic [NCH*CNT_W-1:0] div;
    logic [NCH-1:0]       tick;
    logic [NCH-1:0]       sq;
    logic                 ready;
    logic                 lock_lost;

    int n_checks;
    int n_errors;

    pll_tick_gen #(
        .NCH         (NCH),
        .CNT_W       (CNT_W),
        .LOCK_CYCLES (LOCK_CYCLES)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pll_locked (pll_locked),
        .ch_en      (ch_en),
        .div        (div),
        .tick       (tick),
        .sq         (sq),
        .ready      (ready),
        .lock_lost  (lock_lost)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       locked;
        logic [3:0] tick;
        logic [3:0] sq;
        logic       ready;
        logic       lost;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic l, input logic [3:0] t,
                       input logic [3:0] s, input logic rd, input logic ll);
        vec_t v;
        v.rst = r; v.locked = l; v.tick = t; v.sq = s; v.ready = rd; v.lost = ll;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // One clock edge, then sample 1 ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        rst        = 1'b1;
        pll_locked = 1'b0;
        ch_en      = 4'b1111;
        div        = {16'd5, 16'd2, 16'd1, 16'd0};

        // Reset, then locked 5 / unlocked 1 / locked 8 -> ready on 8th edge.
        add(1, 0, 4'b0000, 4'b0000, 0, 0);
        for (int k = 0; k < 5; k++) add(0, 1, 4'b0000, 4'b0000, 0, 0);
        add(0, 0, 4'b0000, 4'b0000, 0, 0);
        for (int k = 0; k < 7; k++) add(0, 1, 4'b0000, 4'b0000, 0, 0);
        add(0, 1, 4'b0000, 4'b0000, 1, 0);
        // RUN with N = {5,2,1,0}: hand-computed edges E1..E10 after ready.
        add(0, 1, 4'b0011, 4'b0011, 1, 0);
        add(0, 1, 4'b0111, 4'b0100, 1, 0);
        add(0, 1, 4'b0011, 4'b0111, 1, 0);
        add(0, 1, 4'b0111, 4'b0000, 1, 0);
        add(0, 1, 4'b1011, 4'b1011, 1, 0);
        add(0, 1, 4'b0111, 4'b1100, 1, 0);
        add(0, 1, 4'b0011, 4'b1111, 1, 0);
        add(0, 1, 4'b0111, 4'b1000, 1, 0);
        add(0, 1, 4'b0011, 4'b1011, 1, 0);
        add(0, 1, 4'b1111, 4'b0100, 1, 0);

        for (int k = 0; k < vecs.size(); k++) begin
            rst        = vecs[k].rst;
            pll_locked = vecs[k].locked;
            step();
            chk($sformatf("vec%0d_tick", k),  32'(tick),      32'(vecs[k].tick));
            chk($sformatf("vec%0d_sq", k),    32'(sq),        32'(vecs[k].sq));
            chk($sformatf("vec%0d_ready", k), 32'(ready),     32'(vecs[k].ready));
            chk($sformatf("vec%0d_lost", k),  32'(lock_lost), 32'(vecs[k].lost));
        end

        // Ratio change on ch3: last tick at E10, div->3 after E11.
        // Expected ticks at E15 (old period of 5), then E18, E21.
        for (int e = 11; e <= 21; e++) begin
            if (e == 12) div[63:48] = 16'd3;
            step();
            chk($sformatf("ratio_tick3_E%0d", e), 32'(tick[3]),
                32'((e == 15) || (e == 18) || (e == 21)));
            chk($sformatf("ratio_sq3_E%0d", e), 32'(sq[3]),
                32'((e >= 15 && e < 18) || (e >= 21)));
        end

        // ch2 disabled for 7 cycles: silent; ch0/ch1 keep ticking.
        ch_en = 4'b1011;
        for (int k = 0; k < 7; k++) begin
            step();
            chk($sformatf("dis_tick2_%0d", k), 32'(tick[2]), 32'd0);
            chk($sformatf("dis_sq2_%0d", k),   32'(sq[2]),   32'd0);
            chk($sformatf("dis_tick10_%0d", k), 32'(tick[1:0]), 32'd3);
        end
        ch_en = 4'b1111;
        for (int k = 1; k <= 4; k++) begin
            step();
            chk($sformatf("reen_tick2_%0d", k), 32'(tick[2]), 32'((k % 2) == 0));
            chk($sformatf("reen_sq2_%0d", k),   32'(sq[2]),   32'(k == 2 || k == 3));
        end

        // One-cycle lock drop in RUN.
        pll_locked = 1'b0;
        step();
        chk("drop_ready", 32'(ready),     32'd0);
        chk("drop_tick",  32'(tick),      32'd0);
        chk("drop_sq",    32'(sq),        32'd0);
        chk("drop_lost",  32'(lock_lost), 32'd1);
        pll_locked = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step();
            chk($sformatf("relock_ready_%0d", k), 32'(ready), 32'(k == 8));
            chk($sformatf("relock_lost_%0d", k),  32'(lock_lost), 32'd1);
        end
        step();
        chk("relock_first_tick", 32'(tick), 32'b0011);

        // Synchronous reset mid-RUN: outputs cleared, full requalification.
        rst = 1'b1;
        step();
        chk("rst_tick",  32'(tick),      32'd0);
        chk("rst_sq",    32'(sq),        32'd0);
        chk("rst_ready", 32'(ready),     32'd0);
        chk("rst_lost",  32'(lock_lost), 32'd0);
        rst = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            step();
            chk($sformatf("requal_ready_%0d", k), 32'(ready), 32'(k == 8));
            chk($sformatf("requal_lost_%0d", k),  32'(lock_lost), 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
